apb4_slave_regfile: RTL and testbench

Parametrised APB4 completer that holds a register file of NUM_REGS words of DATA_WIDTH bits, with byte-strobe writes, configurable wait states and address-error signalling on Pslverr. It sits behind the APB bus on the DUT side and exports every register plus per-register write pulses to downstream logic. It is the RTL counterpart of the APB bus used by the slave testbench, generalised in data width, depth and response timing.

---
 rtl/apb4_slave_regfile.sv | 137 +++++++++++++
 tb/tb_apb4_slave_regfile.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_slave_regfile.sv
// APB4 completer with a byte-strobed register file.
// Wait states are configurable, and a bad address is reported on Pslverr.
// All registers and per-register write pulses are exported to downstream logic.
module apb4_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                           Pclk,
  input  logic                           Preset,
  input  logic                           Psel,
  input  logic                           Penable,
  input  logic                           Pwrite,
  input  logic [ADDR_WIDTH-1:0]          Paddr,
  input  logic [DATA_WIDTH-1:0]          Pwdata,
  input  logic [DATA_WIDTH/8-1:0]        Pstrb,
  output logic [DATA_WIDTH-1:0]          Prdata,
  output logic                           Pready,
  output logic                           Pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ALIGN_W = $clog2(STRB_W);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_W) - 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      word_idx;
  logic                  addr_err;
  logic                  setup;
  logic                  access_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  // Address decode for the transfer currently on the bus
  always_comb begin
    word_addr = Paddr >> ALIGN_W;
    word_idx  = word_addr[IDX_W-1:0];
    addr_err  = (|(Paddr & ALIGN_MASK)) || (word_addr >= NUM_REGS_A);
    setup     = Psel & ~Penable;
    access_ok = Psel & Penable;
    rd_word   = addr_err ? '0 : regs_q[word_idx];
  end

  // Next-state logic: transfer FSM, read capture, strobed write and pulse
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    write_d    = write_q;
    idx_d      = idx_q;
    prdata_d   = prdata_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d    = ACCESS;
          err_d      = addr_err;
          write_d    = Pwrite;
          idx_d      = word_idx;
          wait_cnt_d = WAIT_INIT;
          if (!Pwrite) prdata_d = rd_word;
        end
      end
      ACCESS: begin
        if (!access_ok) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (write_q && !err_q) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (Pstrb[b]) regs_d[idx_q][b*8 +: 8] = Pwdata[b*8 +: 8];
            end
            wr_pulse_d[idx_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      prdata_q   <= '0;
      regs_q     <= '{default: '0};
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      prdata_q   <= prdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Bus response and flattened register export
  always_comb begin
    Pready   = (state_q == ACCESS) && (wait_cnt_q == 4'd0) && !Preset;
    Pslverr  = Pready & err_q;
    Prdata   = prdata_q;
    wr_pulse = wr_pulse_q;
    reg_q    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Directed bench for apb4_slave_regfile. Three instances are built with 0, 3
// and 2 wait states. Expected read data, error flag and access length are queued
// at setup and popped when Pready is seen.
module tb_apb4_slave_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel0, psel3, psel2;
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;

  logic [31:0]  prdata0, prdata3, prdata2;
  logic         pready0, pready3, pready2;
  logic         pslverr0, pslverr3, pslverr2;
  logic [511:0] regq0, regq3, regq2;
  logic [15:0]  wrp0, wrp3, wrp2;

  always #5 clk = ~clk;

  apb4_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) u0 (
    .Pclk(clk), .Preset(rst), .Psel(psel0), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb), .Prdata(prdata0), .Pready(pready0),
    .Pslverr(pslverr0), .reg_q(regq0), .wr_pulse(wrp0));

  apb4_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3)) u3 (
    .Pclk(clk), .Preset(rst), .Psel(psel3), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb), .Prdata(prdata3), .Pready(pready3),
    .Pslverr(pslverr3), .reg_q(regq3), .wr_pulse(wrp3));

  apb4_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) u2 (
    .Pclk(clk), .Preset(rst), .Psel(psel2), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb), .Prdata(prdata2), .Pready(pready2),
    .Pslverr(pslverr2), .reg_q(regq2), .wr_pulse(wrp2));

  int errors = 0;
  int checks = 0;

  logic [31:0] model [3][16];
  logic [31:0] sb_data [$];
  logic        sb_err  [$];
  int          sb_cyc  [$];

  // d selects the instance: 0 -> 0 waits, 1 -> 3 waits, 2 -> 2 waits
  function automatic int ws(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic get_ready(input int d);
    case (d)
      0:       return pready0;
      1:       return pready3;
      default: return pready2;
    endcase
  endfunction

  function automatic logic get_slverr(input int d);
    case (d)
      0:       return pslverr0;
      1:       return pslverr3;
      default: return pslverr2;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    case (d)
      0:       return prdata0;
      1:       return prdata3;
      default: return prdata2;
    endcase
  endfunction

  function automatic logic [511:0] get_regq(input int d);
    case (d)
      0:       return regq0;
      1:       return regq3;
      default: return regq2;
    endcase
  endfunction

  function automatic logic [15:0] get_wrp(input int d);
    case (d)
      0:       return wrp0;
      1:       return wrp3;
      default: return wrp2;
    endcase
  endfunction

  task automatic set_psel(input int d, input logic v);
    psel0 = 1'b0;
    psel3 = 1'b0;
    psel2 = 1'b0;
    case (d)
      0:       psel0 = v;
      1:       psel3 = v;
      default: psel2 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input int d, input string tag);
    logic [511:0] flat;
    for (int unsigned i = 0; i < 16; i++) flat[i*32 +: 32] = model[d][i];
    checks++;
    assert (get_regq(d) === flat) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, get_regq(d), flat);
    end
  endtask

  task automatic clear_models();
    for (int unsigned d = 0; d < 3; d++)
      for (int unsigned i = 0; i < 16; i++) model[d][i] = '0;
  endtask

  // One APB transfer: setup on this negedge, then access until Pready.
  // Returns on the negedge where Pready is seen, so a following call is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    logic        e;
    logic [31:0] expd;
    logic [31:0] sd;
    logic        se;
    int          sc;
    int          n;
    logic        done;
    e    = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd16);
    expd = e ? 32'h0 : model[d][addr[5:2]];
    @(negedge clk);
    set_psel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    sb_data.push_back(expd);
    sb_err.push_back(e);
    sb_cyc.push_back(ws(d) + 1);
    @(negedge clk);
    penable = 1'b1;
    n    = 1;
    done = 1'b0;
    while (!done && n <= 20) begin
      if (get_ready(d)) done = 1'b1;
      else begin
        chk("slverr_wait", 64'(get_slverr(d)), 64'd0);
        @(negedge clk);
        n++;
      end
    end
    sd = sb_data.pop_front();
    se = sb_err.pop_front();
    sc = sb_cyc.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout observed=no Pready expected=Pready within 20 cycles");
    end else begin
      if (!wr) chk("rdata", 64'(get_rdata(d)), 64'(sd));
      chk("slverr", 64'(get_slverr(d)), 64'(se));
      chk("cycles", 64'(n), 64'(sc));
      if (wr && !e) begin
        for (int unsigned b = 0; b < 4; b++)
          if (strb[b]) model[d][addr[5:2]][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_psel(0, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  initial begin
    clear_models();
    rst = 1'b1;
    psel0 = 1'b0; psel3 = 1'b0; psel2 = 1'b0;
    penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    // Reset: 2 cycles
    @(negedge clk);
    chk("rst_pready", 64'(pready0), 64'd0);
    chk("rst_slverr", 64'(pslverr0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_prdata", 64'(get_rdata(d)), 64'd0);
      chk("rst_wrp", 64'(get_wrp(d)), 64'd0);
      chk("rst_ready", 64'(get_ready(d)), 64'd0);
      chk_regs(d, "rst_regq");
    end

    // Zero-wait write then read of 0x08
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    idle();
    chk("wr_pulse", 64'(wrp0), 64'h0004);
    chk_regs(0, "regq_w8");
    @(negedge clk);
    chk("wr_pulse_off", 64'(wrp0), 64'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);

    // Byte strobes, back-to-back, read right after write
    xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF);
    xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'hF);
    idle();
    chk("reg1_strb", 64'(regq0[63:32]), 64'h11BB33DD);
    chk_regs(0, "regq_strb");

    // Three wait states
    xfer(1, 1'b1, 32'h10, 32'h12345678, 4'hF);
    idle();
    chk("wr_pulse_ws3", 64'(wrp3), 64'h0010);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h41, 32'h0, 4'h0);
    idle();

    // Address errors
    xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    idle();
    chk("err_wr_pulse", 64'(wrp0), 64'h0);
    chk_regs(0, "err_regq");
    xfer(0, 1'b0, 32'h06, 32'h0, 4'h0);
    idle();

    // Abort in the second access cycle with 2 wait states
    xfer(2, 1'b1, 32'h08, 32'h55AA55AA, 4'hF);
    idle();
    @(negedge clk);
    set_psel(2, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_ready1", 64'(pready2), 64'd0);
    @(negedge clk);
    set_psel(2, 1'b0);
    penable = 1'b0;
    chk("abort_ready2", 64'(pready2), 64'd0);
    @(negedge clk);
    chk("abort_wrp", 64'(wrp2), 64'h0);
    chk("abort_idle", 64'(pready2), 64'd0);
    chk_regs(2, "abort_regq");
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0);
    idle();

    // Reset coinciding with the completion edge of a write to 0x0C
    @(negedge clk);
    set_psel(0, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_psel(0, 1'b0);
    penable = 1'b0;
    clear_models();
    chk("rstc_wrp", 64'(wrp0), 64'h0);
    chk("rstc_reg3", 64'(regq0[127:96]), 64'h0);
    chk("rstc_ready", 64'(pready0), 64'd0);
    chk_regs(0, "rstc_regq");
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
